// File: rtl/fsm_serial_pkg.sv
// Shared types and helpers for the bit-serial arithmetic engine.
package fsm_serial_pkg;

  // Operation selected per word; encodings match the in_mode port.
  typedef enum logic [1:0] {
    PASS = 2'b00,
    NEG  = 2'b01,
    INC  = 2'b10,
    DEC  = 2'b11
  } mode_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Bit-counter width for a given word width (WIDTH is at least 2).
  function automatic int cnt_width(input int w);
    return (w > 32'sd1) ? $clog2(w) : 32'sd1;
  endfunction

  // Initial carry/borrow/seen-one bit for each mode.
  function automatic logic st_preset(input mode_e m);
    case (m)
      PASS:    return 1'b0;
      NEG:     return 1'b0;
      INC:     return 1'b1;
      DEC:     return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fsm_serial_engine_cell.sv
// Per-bit Mealy logic: given the current operand bit and state bit,
// produce the result bit, the next state bit and the wrap flag.
module serial_bit_cell
  import fsm_serial_pkg::*;
(
  input  mode_e mode,
  input  logic  st,
  input  logic  b,
  input  logic  last,
  output logic  out_bit,
  output logic  st_next,
  output logic  ovf
);

  // Mode-dependent output bit, next state bit and final-bit overflow.
  always_comb begin
    out_bit = b;
    st_next = st;
    ovf     = 1'b0;
    case (mode)
      PASS: begin
        out_bit = b;
        st_next = st;
        ovf     = 1'b0;
      end
      NEG: begin
        // Copy bits up to and including the first one, invert after it.
        out_bit = b ^ st;
        st_next = st | b;
        ovf     = last & b & ~st;
      end
      INC: begin
        out_bit = b ^ st;
        st_next = b & st;
        ovf     = last & b & st;
      end
      DEC: begin
        out_bit = b ^ st;
        st_next = st & ~b;
        ovf     = last & st & ~b;
      end
      default: begin
        out_bit = b;
        st_next = st;
        ovf     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fsm_serial_engine.sv
// Bit-serial pass/negate/increment/decrement engine with valid/ready
// handshakes on both sides; one operand bit is processed per clock, LSB first.
module fsm_serial_engine
  import fsm_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sreg_r;
  logic [WIDTH-1:0] res_r;
  mode_e            mode_r;
  logic             st_r;
  logic             ovf_r;
  logic             last_s;
  logic             accept_s;
  logic             cell_out_s;
  logic             cell_st_s;
  logic             cell_ovf_s;

  assign accept_s = (state_r == IDLE) && in_valid;
  assign last_s   = (cnt_r == CW'(WIDTH - 1));

  serial_bit_cell u_cell (
    .mode    (mode_r),
    .st      (st_r),
    .b       (sreg_r[0]),
    .last    (last_s),
    .out_bit (cell_out_s),
    .st_next (cell_st_s),
    .ovf     (cell_ovf_s)
  );

  // Next-state decode for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nxt_s = RUN;
        else          state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE: begin
        if (out_ready) state_nxt_s = IDLE;
        else           state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Operand capture, serial shifting, counter and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r  <= '0;
      sreg_r <= '0;
      res_r  <= '0;
      mode_r <= PASS;
      st_r   <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            sreg_r <= in_data;
            mode_r <= mode_e'(in_mode);
            cnt_r  <= '0;
            st_r   <= st_preset(mode_e'(in_mode));
            ovf_r  <= 1'b0;
          end else begin
            sreg_r <= sreg_r;
          end
        end
        RUN: begin
          // Result bits enter at the MSB so the word is aligned after WIDTH shifts.
          sreg_r <= {1'b0, sreg_r[WIDTH-1:1]};
          res_r  <= {cell_out_s, res_r[WIDTH-1:1]};
          st_r   <= cell_st_s;
          ovf_r  <= cell_ovf_s;
          if (!last_s) cnt_r <= cnt_r + CW'(1);
          else         cnt_r <= cnt_r;
        end
        DONE: begin
          res_r <= res_r;
          ovf_r <= ovf_r;
        end
        default: begin
          cnt_r <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign out_data  = res_r;
  assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_fsm_serial_engine.sv
// Directed, table-driven bench for fsm_serial_engine at WIDTH 8, 2 and 16.
module tb_fsm_serial_engine;

  logic        clk;
  logic        rst_n;
  logic        iv   [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic        bsy  [3];
  logic [1:0]  im   [3];
  logic [31:0] idata[3];
  logic        oo   [3];
  logic [31:0] od   [3];
  logic [7:0]  d8;
  logic [1:0]  d2;
  logic [15:0] d16;
  int          wid  [3];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          idx;
    logic [1:0]  mode;
    logic [31:0] data;
    logic [31:0] exp_d;
    logic        exp_o;
    string       name;
  } vec_t;

  vec_t vecs[$];

  fsm_serial_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(idata[0][7:0]), .in_mode(im[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_data(d8), .out_ovf(oo[0]), .busy(bsy[0])
  );

  fsm_serial_engine #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(idata[1][1:0]), .in_mode(im[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_data(d2), .out_ovf(oo[1]), .busy(bsy[1])
  );

  fsm_serial_engine #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(idata[2][15:0]), .in_mode(im[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_data(d16), .out_ovf(oo[2]), .busy(bsy[2])
  );

  // Zero-extend each instance's result so checks can share one width.
  always_comb begin
    od[0] = {24'd0, d8};
    od[1] = {30'd0, d2};
    od[2] = {16'd0, d16};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Offer one word, wait (bounded) for the result, check it, then consume it.
  task automatic run_word(input int i, input logic [1:0] m, input logic [31:0] dat,
                          input logic [31:0] ed, input logic eo, input string nm);
    int lat;
    @(negedge clk);
    chk({nm, " in_ready"}, 32'(ir[i]), 32'd1);
    iv[i] = 1'b1; im[i] = m; idata[i] = dat;
    @(negedge clk);
    iv[i] = 1'b0; idata[i] = 32'hDEAD_BEEF; im[i] = ~m;
    chk({nm, " busy"}, 32'(bsy[i]), 32'd1);
    lat = 0;
    while (!ov[i] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(wid[i]));
    chk({nm, " data"}, od[i], ed);
    chk({nm, " ovf"}, 32'(oo[i]), 32'(eo));
    ordy[i] = 1'b1;
    @(negedge clk);
    ordy[i] = 1'b0;
    chk({nm, " out_valid after take"}, 32'(ov[i]), 32'd0);
    chk({nm, " in_ready after take"}, 32'(ir[i]), 32'd1);
  endtask

  initial begin
    int seen;
    wid[0] = 8; wid[1] = 2; wid[2] = 16;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; im[i] = 2'b00; idata[i] = 32'd0;
    end

    vecs.push_back('{0, 2'b01, 32'd23,     32'd233,    1'b0, "w8 neg 23"});
    vecs.push_back('{0, 2'b01, 32'd128,    32'd128,    1'b1, "w8 neg 128"});
    vecs.push_back('{0, 2'b01, 32'd0,      32'd0,      1'b0, "w8 neg 0"});
    vecs.push_back('{0, 2'b10, 32'd255,    32'd0,      1'b1, "w8 inc 255"});
    vecs.push_back('{0, 2'b10, 32'd74,     32'd75,     1'b0, "w8 inc 74"});
    vecs.push_back('{0, 2'b11, 32'd0,      32'd255,    1'b1, "w8 dec 0"});
    vecs.push_back('{0, 2'b11, 32'd96,     32'd95,     1'b0, "w8 dec 96"});
    vecs.push_back('{0, 2'b00, 32'd170,    32'd170,    1'b0, "w8 pass 170"});
    vecs.push_back('{1, 2'b01, 32'd2,      32'd2,      1'b1, "w2 neg 2"});
    vecs.push_back('{1, 2'b01, 32'd1,      32'd3,      1'b0, "w2 neg 1"});
    vecs.push_back('{1, 2'b10, 32'd3,      32'd0,      1'b1, "w2 inc 3"});
    vecs.push_back('{1, 2'b11, 32'd0,      32'd3,      1'b1, "w2 dec 0"});
    vecs.push_back('{2, 2'b10, 32'hFFFF,   32'h0000,   1'b1, "w16 inc ffff"});
    vecs.push_back('{2, 2'b11, 32'h0000,   32'hFFFF,   1'b1, "w16 dec 0"});
    vecs.push_back('{2, 2'b01, 32'h8000,   32'h8000,   1'b1, "w16 neg 8000"});
    vecs.push_back('{2, 2'b01, 32'h0001,   32'hFFFF,   1'b0, "w16 neg 1"});
    vecs.push_back('{2, 2'b10, 32'h00FF,   32'h0100,   1'b0, "w16 inc 00ff"});

    // Reset values while rst_n is held low.
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("reset in_ready", 32'(ir[i]), 32'd1);
      chk("reset out_valid", 32'(ov[i]), 32'd0);
      chk("reset out_data", od[i], 32'd0);
      chk("reset out_ovf", 32'(oo[i]), 32'd0);
      chk("reset busy", 32'(bsy[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      run_word(vecs[k].idx, vecs[k].mode, vecs[k].data, vecs[k].exp_d, vecs[k].exp_o, vecs[k].name);
    end

    // Backpressure: hold the result in DONE while a new word is offered.
    @(negedge clk);
    iv[0] = 1'b1; im[0] = 2'b10; idata[0] = 32'd74;
    @(negedge clk);
    iv[0] = 1'b0;
    seen = 0;
    while (!ov[0] && seen < 200) begin
      @(negedge clk);
      seen++;
    end
    chk("bp latency", 32'(seen), 32'd8);
    iv[0] = 1'b1; im[0] = 2'b01; idata[0] = 32'd5;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp out_valid held", 32'(ov[0]), 32'd1);
      chk("bp data stable", od[0], 32'd75);
      chk("bp ovf stable", 32'(oo[0]), 32'd0);
      chk("bp in_ready low", 32'(ir[0]), 32'd0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    chk("bp idle after take", 32'(ir[0]), 32'd1);
    chk("bp out_valid cleared", 32'(ov[0]), 32'd0);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ov[0] || bsy[0]) seen++;
    end
    chk("bp ignored word not run", 32'(seen), 32'd0);
    run_word(0, 2'b00, 32'd170, 32'd170, 1'b0, "b2b first");
    run_word(0, 2'b11, 32'd96, 32'd95, 1'b0, "b2b second");

    // Reset mid-RUN at cnt=3 of NEG 39.
    @(negedge clk);
    iv[0] = 1'b1; im[0] = 2'b01; idata[0] = 32'd39;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst pre busy", 32'(bsy[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst in_ready", 32'(ir[0]), 32'd1);
    chk("async rst out_valid", 32'(ov[0]), 32'd0);
    chk("async rst out_data", od[0], 32'd0);
    chk("async rst out_ovf", 32'(oo[0]), 32'd0);
    chk("async rst busy", 32'(bsy[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    chk("rst no stale out_valid", 32'(seen), 32'd0);
    run_word(0, 2'b10, 32'd110, 32'd111, 1'b0, "post rst inc 110");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
